// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the JTDSP16 Y-space address unit.
// Optional build macro: JTDSP16_YAAU_CIRC_EN (circular-buffer registers rb/re).
package jtdsp16_pkg;

    localparam int DEF_AW = 11;

    // Post-modify encodings carried in y_field[1:0]
    typedef enum logic [1:0] {
        MOD_NONE = 2'd0,
        MOD_INC  = 2'd1,
        MOD_DEC  = 2'd2,
        MOD_J    = 2'd3
    } mod_e;

    // Register codes used by r_sel for loads and readback
    typedef enum logic [2:0] {
        RSEL_R0  = 3'd0,
        RSEL_R1  = 3'd1,
        RSEL_R2  = 3'd2,
        RSEL_R3  = 3'd3,
        RSEL_RB  = 3'd4,
        RSEL_RE  = 3'd5,
        RSEL_J   = 3'd6,
        RSEL_RSV = 3'd7
    } rsel_e;

endpackage

// File: rtl/jtdsp16_yaau_ptr.sv
// One Y-space pointer register with post-modify and optional circular wrap.
// Optional build macro: JTDSP16_YAAU_CIRC_EN (wrap from re back to rb).
module jtdsp16_yaau_ptr
    import jtdsp16_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          mod_en,
    input  mod_e          mod,
    input  logic          load_en,
    input  logic [AW-1:0] load_val,
    input  logic [AW-1:0] j_low,
`ifdef JTDSP16_YAAU_CIRC_EN
    input  logic [AW-1:0] rb,
    input  logic [AW-1:0] re,
`endif
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_reg;
    logic [AW-1:0] ptr_next;
    logic [AW-1:0] inc;
    logic [AW-1:0] sum;

    // Next pointer: an explicit load beats the post-modify of the same cycle
    always_comb begin
        inc = '0;
        case (mod)
            MOD_INC: inc = AW'(1);
            MOD_DEC: inc = '1;
            MOD_J:   inc = j_low;
            default: inc = '0;
        endcase
        sum = ptr_reg + inc;
`ifdef JTDSP16_YAAU_CIRC_EN
        // Only forward steps wrap; a zero re disables the buffer
        if ((mod == MOD_INC || mod == MOD_J) && re != '0 && ptr_reg == re)
            sum = rb;
`endif
        ptr_next = ptr_reg;
        if (load_en)
            ptr_next = load_val;
        else if (mod_en)
            ptr_next = sum;
    end

    // Pointer state, frozen while cen is low
    always_ff @(posedge clk) begin
        if (!rst)
            ptr_reg <= '0;
        else if (cen)
            ptr_reg <= ptr_next;
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/jtdsp16_yaau.sv
// JTDSP16 Y-space address arithmetic unit and data-RAM port.
// Optional build macro: JTDSP16_YAAU_CIRC_EN (rb/re registers and circular wrap).
module jtdsp16_yaau
    import jtdsp16_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          acc_en,
    input  logic [3:0]    y_field,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    input  logic          r_load,
    input  logic [2:0]    r_sel,
    input  logic [15:0]   long_imm,
    input  logic [15:0]   ram_q,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [15:0]   ram_din,
    output logic [15:0]   ram_dout,
    output logic          ram_load,
    output logic [15:0]   reg_dout
);

    logic [3:0][AW-1:0] ptr_q;
    logic [15:0]        j_reg;
    logic               ram_load_reg;
`ifdef JTDSP16_YAAU_CIRC_EN
    logic [AW-1:0]      rb_reg;
    logic [AW-1:0]      re_reg;
`endif

    // Four pointers share j (and rb/re when present)
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ptr
            jtdsp16_yaau_ptr #(.AW(AW)) u_ptr (
                .rst      (rst),
                .clk      (clk),
                .cen      (cen),
                .mod_en   (acc_en && y_field[3:2] == 2'(gi)),
                .mod      (mod_e'(y_field[1:0])),
                .load_en  (r_load && r_sel == 3'(gi)),
                .load_val (long_imm[AW-1:0]),
                .j_low    (j_reg[AW-1:0]),
`ifdef JTDSP16_YAAU_CIRC_EN
                .rb       (rb_reg),
                .re       (re_reg),
`endif
                .ptr      (ptr_q[gi])
            );
        end
    endgenerate

    // Shared modifier registers and the read-valid flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            j_reg        <= '0;
            ram_load_reg <= 1'b0;
`ifdef JTDSP16_YAAU_CIRC_EN
            rb_reg       <= '0;
            re_reg       <= '0;
`endif
        end else if (cen) begin
            ram_load_reg <= acc_en & ~wr_en;
            if (r_load && r_sel == RSEL_J)
                j_reg <= long_imm;
`ifdef JTDSP16_YAAU_CIRC_EN
            if (r_load && r_sel == RSEL_RB)
                rb_reg <= long_imm[AW-1:0];
            if (r_load && r_sel == RSEL_RE)
                re_reg <= long_imm[AW-1:0];
`endif
        end
    end

    // Register readback; pointers zero-extended, j already 16 bits wide
    always_comb begin
        reg_dout = '0;
        case (rsel_e'(r_sel))
            RSEL_R0, RSEL_R1, RSEL_R2, RSEL_R3:
                reg_dout[AW-1:0] = ptr_q[r_sel[1:0]];
`ifdef JTDSP16_YAAU_CIRC_EN
            RSEL_RB: reg_dout[AW-1:0] = rb_reg;
            RSEL_RE: reg_dout[AW-1:0] = re_reg;
`endif
            RSEL_J:  reg_dout = j_reg;
            default: reg_dout = '0;
        endcase
    end

    assign ram_addr = ptr_q[y_field[3:2]];
    assign ram_we   = acc_en & wr_en & cen;
    assign ram_din  = wr_data;
    assign ram_dout = ram_q;
    assign ram_load = ram_load_reg;

endmodule

// File: tb/tb_jtdsp16_yaau.sv
// Self-checking bench for jtdsp16_yaau (AW=11): register table plus access sequences.
module tb_jtdsp16_yaau;

    localparam int AW = 11;

    logic          rst, clk, cen, acc_en, wr_en, r_load;
    logic [3:0]    y_field;
    logic [15:0]   wr_data, long_imm, ram_q;
    logic [2:0]    r_sel;
    logic [AW-1:0] ram_addr;
    logic          ram_we, ram_load;
    logic [15:0]   ram_din, ram_dout, reg_dout;

    int n_cmp = 0;
    int n_bad = 0;

    jtdsp16_yaau #(.AW(AW)) dut (
        .rst      (rst),
        .clk      (clk),
        .cen      (cen),
        .acc_en   (acc_en),
        .y_field  (y_field),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .r_load   (r_load),
        .r_sel    (r_sel),
        .long_imm (long_imm),
        .ram_q    (ram_q),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .ram_load (ram_load),
        .reg_dout (reg_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] val;
        logic [15:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%04h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input logic [2:0] sel, input logic [15:0] val);
        r_load = 1'b1; r_sel = sel; long_imm = val;
        tick();
        r_load = 1'b0;
    endtask

    task automatic read_reg(input string name, input logic [2:0] sel, input logic [15:0] exp);
        r_sel = sel;
        #1;
        check(name, reg_dout, exp);
    endtask

    logic [AW-1:0] circ_exp [4];

    initial begin
        rst = 1'b0; cen = 1'b1; acc_en = 1'b0; wr_en = 1'b0; r_load = 1'b0;
        y_field = '0; wr_data = '0; long_imm = '0; ram_q = 16'h5A5A; r_sel = '0;

`ifdef JTDSP16_YAAU_CIRC_EN
        vecs[0] = '{3'd4, 16'h0456, 16'h0456};
        vecs[1] = '{3'd5, 16'hF7FF, 16'h07FF};
`else
        vecs[0] = '{3'd4, 16'h0456, 16'h0000};
        vecs[1] = '{3'd5, 16'hF7FF, 16'h0000};
`endif
        vecs[2] = '{3'd0, 16'hFFFF, 16'h07FF};
        vecs[3] = '{3'd1, 16'h0123, 16'h0123};
        vecs[4] = '{3'd6, 16'h8001, 16'h8001};
        vecs[5] = '{3'd7, 16'h1234, 16'h0000};

        // Reset held two cycles
        tick(); tick();
        for (int s = 0; s < 8; s++) read_reg($sformatf("reset_reg%0d", s), 3'(s), 16'h0000);
        check("reset_ram_load", 16'(ram_load), 16'h0);
        rst = 1'b1;

        // Register load/readback table
        for (int i = 0; i < 6; i++) begin
            load_reg(vecs[i].sel, vecs[i].val);
            read_reg($sformatf("table%0d_sel%0d", i, vecs[i].sel), vecs[i].sel, vecs[i].exp);
        end
        load_reg(3'd4, 16'h0); load_reg(3'd5, 16'h0); load_reg(3'd6, 16'h0);

        // Post-increment reads, back to back
        load_reg(3'd1, 16'h0010);
        acc_en = 1'b1; y_field = 4'b0101; #1;
        check("inc_addr0", 16'(ram_addr), 16'h0010);
        tick();
        check("inc_addr1", 16'(ram_addr), 16'h0011);
        check("inc_load1", 16'(ram_load), 16'h1);
        tick();
        check("inc_addr2", 16'(ram_addr), 16'h0012);
        check("inc_load2", 16'(ram_load), 16'h1);
        tick();
        acc_en = 1'b0;
        check("inc_load3", 16'(ram_load), 16'h1);
        check("inc_dout", ram_dout, 16'h5A5A);
        tick();
        check("inc_load_off", 16'(ram_load), 16'h0);
        read_reg("inc_r1", 3'd1, 16'h0013);

        // Negative j and decrement from zero
        load_reg(3'd6, 16'hFFFE);
        load_reg(3'd2, 16'h0001);
        read_reg("j_sign", 3'd6, 16'hFFFE);
        acc_en = 1'b1; y_field = 4'b1011; #1;
        check("negj_addr", 16'(ram_addr), 16'h0001);
        tick();
        acc_en = 1'b0;
        read_reg("negj_r2", 3'd2, 16'h07FF);
        load_reg(3'd3, 16'h0000);
        acc_en = 1'b1; y_field = 4'b1110;
        tick();
        acc_en = 1'b0;
        read_reg("dec_wrap_r3", 3'd3, 16'h07FF);

        // Circular buffer walk
        load_reg(3'd4, 16'h0020);
        load_reg(3'd5, 16'h0023);
        load_reg(3'd0, 16'h0022);
`ifdef JTDSP16_YAAU_CIRC_EN
        circ_exp[0] = 11'h022; circ_exp[1] = 11'h023; circ_exp[2] = 11'h020; circ_exp[3] = 11'h021;
`else
        circ_exp[0] = 11'h022; circ_exp[1] = 11'h023; circ_exp[2] = 11'h024; circ_exp[3] = 11'h025;
`endif
        acc_en = 1'b1; y_field = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("circ_addr%0d", k), 16'(ram_addr), 16'(circ_exp[k]));
            tick();
        end
        acc_en = 1'b0;

        // Store colliding with a load of the same pointer
        load_reg(3'd3, 16'h0100);
        acc_en = 1'b1; wr_en = 1'b1; wr_data = 16'hBEEF; y_field = 4'b1101;
        r_load = 1'b1; r_sel = 3'd3; long_imm = 16'h0200; #1;
        check("wr_we", 16'(ram_we), 16'h1);
        check("wr_addr", 16'(ram_addr), 16'h0100);
        check("wr_din", ram_din, 16'hBEEF);
        tick();
        acc_en = 1'b0; wr_en = 1'b0; r_load = 1'b0; #1;
        check("wr_we_off", 16'(ram_we), 16'h0);
        check("wr_no_load", 16'(ram_load), 16'h0);
        read_reg("wr_r3", 3'd3, 16'h0200);

        // cen gating: read, then freeze three cycles
        load_reg(3'd1, 16'h0040);
        acc_en = 1'b1; y_field = 4'b0101;
        tick();
        cen = 1'b0; r_load = 1'b1; r_sel = 3'd1; long_imm = 16'h0333; #1;
        check("cen_we_gated", 16'(ram_we), 16'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("cen_hold_load%0d", k), 16'(ram_load), 16'h1);
            check($sformatf("cen_hold_r1_%0d", k), reg_dout, 16'h0041);
        end
        r_load = 1'b0; acc_en = 1'b0; cen = 1'b1;
        tick();
        check("cen_release_load", 16'(ram_load), 16'h0);
        read_reg("cen_release_r1", 3'd1, 16'h0041);

        // Read issued in a reset cycle produces no ram_load
        acc_en = 1'b1; y_field = 4'b0101; rst = 1'b0;
        tick();
        rst = 1'b1; acc_en = 1'b0; #1;
        check("rst_mid_load", 16'(ram_load), 16'h0);
        read_reg("rst_mid_r1", 3'd1, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
